// File: rtl/cpu_pkg.sv
// Shared types and sizing for the 16-bit pipeline's memory stage.
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int ADDR_BITS  = 10;
  localparam int WAIT_CNT_W = 4;
  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = 4'd15;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              wbs;
    logic              wme;
    logic              ni;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
  } memwb_t;

  localparam memwb_t MEMWB_RESET = '{
    wbs:        1'b0,
    wme:        1'b0,
    ni:         1'b1,
    alu_result: '0,
    read_data:  '0
  };

endpackage

// File: rtl/mem_handshake_fsm.sv
// Req/ack handshake with the data memory: request registers, wait counter,
// pipeline stall and abandon-on-timeout.
module mem_handshake_fsm
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 start_we,
  input  logic [ADDR_BITS-1:0] start_addr,
  input  logic [DATA_W-1:0]    start_wdata,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic                 timeout
);

  mem_state_t              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_BITS-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;

  logic in_access;
  logic at_limit;

  assign in_access = (state_q == ACCESS);
  assign at_limit  = (cnt_q == WAIT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = start_we;
          addr_d  = start_addr;
          wdata_d = start_wdata;
        end
      end
      ACCESS: begin
        if (mem_ack || at_limit) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // An ack arriving in the final allowed cycle still counts as completion.
  assign stall   = (!in_access && start) || (in_access && !mem_ack && !at_limit);
  assign done    = in_access && mem_ack;
  assign timeout = in_access && !mem_ack && at_limit;
  assign busy    = in_access;

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: range check, handshake with data memory, MEM/WB register
// and sticky error flags.
module memory_access_stage
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wbs_in,
  input  logic                 wme_in,
  input  logic                 mm_in,
  input  logic                 wm_in,
  input  logic                 ni_in,
  input  logic [DATA_W-1:0]    ALUresult_in,
  input  logic [DATA_W-1:0]    memData_in,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic                 wbs_out,
  output logic                 wme_out,
  output logic                 ni_out,
  output logic [DATA_W-1:0]    alu_result_out,
  output logic [DATA_W-1:0]    read_data_out,
  output logic                 err_timeout,
  output logic                 err_range
);

  logic is_mem_op;
  logic addr_high_set;
  logic range_bad;
  logic start;
  logic busy;
  logic done;
  logic timeout;

  memwb_t memwb_q, memwb_d;
  logic   err_timeout_q, err_timeout_d;
  logic   err_range_q, err_range_d;

  assign is_mem_op     = !ni_in && (mm_in || wm_in);
  assign addr_high_set = |ALUresult_in[DATA_W-1:ADDR_BITS];
  assign start         = is_mem_op && !addr_high_set;
  // While an access is in flight the held instruction was already range-checked.
  assign range_bad     = is_mem_op && addr_high_set && !busy;

  mem_handshake_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_we    (wm_in),
    .start_addr  (ALUresult_in[ADDR_BITS-1:0]),
    .start_wdata (memData_in),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .timeout     (timeout)
  );

  always_comb begin
    memwb_d = memwb_q;
    if (stall || timeout || range_bad) begin
      memwb_d.ni  = 1'b1;
      memwb_d.wme = 1'b0;
    end else begin
      memwb_d.wbs        = wbs_in;
      memwb_d.wme        = wme_in;
      memwb_d.ni         = ni_in;
      memwb_d.alu_result = ALUresult_in;
      if (done && !mem_we) begin
        memwb_d.read_data = mem_rdata;
      end
    end
  end

  always_comb begin
    err_timeout_d = err_timeout_q || timeout;
    err_range_d   = err_range_q || range_bad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      memwb_q       <= MEMWB_RESET;
      err_timeout_q <= 1'b0;
      err_range_q   <= 1'b0;
    end else begin
      memwb_q       <= memwb_d;
      err_timeout_q <= err_timeout_d;
      err_range_q   <= err_range_d;
    end
  end

  assign wbs_out        = memwb_q.wbs;
  assign wme_out        = memwb_q.wme;
  assign ni_out         = memwb_q.ni;
  assign alu_result_out = memwb_q.alu_result;
  assign read_data_out  = memwb_q.read_data;
  assign err_timeout    = err_timeout_q;
  assign err_range      = err_range_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with hand-computed expectations.
module tb_memory_access_stage;

  logic        clk;
  logic        rst_n;
  logic        wbs_in, wme_in, mm_in, wm_in, ni_in;
  logic [15:0] ALUresult_in, memData_in;
  logic        stall, mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wbs_out, wme_out, ni_out;
  logic [15:0] alu_result_out, read_data_out;
  logic        err_timeout, err_range;

  int total = 0;
  int bad   = 0;

  memory_access_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wbs_in         (wbs_in),
    .wme_in         (wme_in),
    .mm_in          (mm_in),
    .wm_in          (wm_in),
    .ni_in          (ni_in),
    .ALUresult_in   (ALUresult_in),
    .memData_in     (memData_in),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ack        (mem_ack),
    .wbs_out        (wbs_out),
    .wme_out        (wme_out),
    .ni_out         (ni_out),
    .alu_result_out (alu_result_out),
    .read_data_out  (read_data_out),
    .err_timeout    (err_timeout),
    .err_range      (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bubble();
    ni_in = 1'b1; mm_in = 1'b0; wm_in = 1'b0; wme_in = 1'b0; wbs_in = 1'b0;
    ALUresult_in = 16'h0000; memData_in = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
  endtask

  // Presents one instruction, emulates a memory acking after ack_after request
  // cycles (0 = never), and returns once the stage retires it.
  task automatic run_mem_op(input logic mm, input logic wm, input logic wme, input logic wbs,
                            input logic [15:0] alu, input logic [15:0] wdata,
                            input int ack_after, input logic [15:0] rdata,
                            output int req_cycles, output int stall_cycles, output logic retired,
                            output logic f_we, output logic [9:0] f_addr, output logic [15:0] f_wdata);
    logic st;
    logic ack;
    req_cycles = 0; stall_cycles = 0; retired = 1'b0;
    f_we = 1'b0; f_addr = '0; f_wdata = '0;
    ni_in = 1'b0; mm_in = mm; wm_in = wm; wme_in = wme; wbs_in = wbs;
    ALUresult_in = alu; memData_in = wdata;
    for (int c = 0; c < 40; c++) begin
      ack = mem_req && (ack_after != 0) && (ack_after == req_cycles + 1);
      if (mem_req) begin
        if (req_cycles == 0) begin
          f_we = mem_we; f_addr = mem_addr; f_wdata = mem_wdata;
        end
        req_cycles++;
      end
      mem_ack = ack;
      mem_rdata = ack ? rdata : 16'hDEAD;
      #1;
      st = stall;
      if (st) stall_cycles++;
      tick();
      mem_ack = 1'b0;
      if (!st) begin
        retired = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    set_bubble();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (mem_addr !== 10'h000) begin bad++; $display("FAIL reset_mem_addr got=%h exp=000", mem_addr); end
    total++; if (mem_wdata !== 16'h0000) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
    total++; if ({wbs_out, wme_out, ni_out} !== 3'b001) begin bad++; $display("FAIL reset_ctrl got=%b exp=001", {wbs_out, wme_out, ni_out}); end
    total++; if (alu_result_out !== 16'h0000) begin bad++; $display("FAIL reset_alu got=%h exp=0000", alu_result_out); end
    total++; if (read_data_out !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", read_data_out); end
    total++; if ({err_timeout, err_range} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {err_timeout, err_range}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    $display("reset: checked reset values");
  endtask

  task automatic test_alu_passthrough();
    ni_in = 1'b0; mm_in = 1'b0; wm_in = 1'b0; wme_in = 1'b1; wbs_in = 1'b0;
    ALUresult_in = 16'h0005; memData_in = 16'h0000;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", stall); end
    tick();
    total++; if (alu_result_out !== 16'h0005) begin bad++; $display("FAIL alu_result got=%h exp=0005", alu_result_out); end
    total++; if ({wme_out, ni_out} !== 2'b10) begin bad++; $display("FAIL alu_ctrl got=%b exp=10", {wme_out, ni_out}); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL alu_req got=%b exp=0", mem_req); end
    set_bubble();
    $display("alu passthrough: result=%h", alu_result_out);
  endtask

  task automatic test_load();
    int r, s; logic ok, fwe; logic [9:0] fa; logic [15:0] fd;
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000, 3, 16'h00AB, r, s, ok, fwe, fa, fd);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL load_retire got=%b exp=1", ok); end
    total++; if (r != 3) begin bad++; $display("FAIL load_req_cycles got=%0d exp=3", r); end
    total++; if (s != 3) begin bad++; $display("FAIL load_stall_cycles got=%0d exp=3", s); end
    total++; if ({fwe, fa} !== {1'b0, 10'h003}) begin bad++; $display("FAIL load_req_fields got=%b/%h exp=0/003", fwe, fa); end
    total++; if (read_data_out !== 16'h00AB) begin bad++; $display("FAIL load_rdata got=%h exp=00ab", read_data_out); end
    total++; if ({wbs_out, wme_out, ni_out} !== 3'b110) begin bad++; $display("FAIL load_ctrl got=%b exp=110", {wbs_out, wme_out, ni_out}); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL load_req_drop got=%b exp=0", mem_req); end
    set_bubble();
    $display("load: req=%0d stall=%0d rdata=%h", r, s, read_data_out);
  endtask

  task automatic test_store();
    int r, s; logic ok, fwe; logic [9:0] fa; logic [15:0] fd;
    run_mem_op(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h1234, 1, 16'h5555, r, s, ok, fwe, fa, fd);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL store_retire got=%b exp=1", ok); end
    total++; if (r != 1 || s != 1) begin bad++; $display("FAIL store_cycles got=req%0d/stall%0d exp=1/1", r, s); end
    total++; if ({fwe, fa, fd} !== {1'b1, 10'h010, 16'h1234}) begin bad++; $display("FAIL store_req_fields got=%b/%h/%h exp=1/010/1234", fwe, fa, fd); end
    total++; if (read_data_out !== 16'h00AB) begin bad++; $display("FAIL store_rdata_held got=%h exp=00ab", read_data_out); end
    total++; if ({wme_out, ni_out} !== 2'b00) begin bad++; $display("FAIL store_ctrl got=%b exp=00", {wme_out, ni_out}); end
    set_bubble();
    $display("store: req=%0d stall=%0d addr=%h data=%h", r, s, fa, fd);
  endtask

  task automatic test_out_of_range();
    int r, s; logic ok, fwe; logic [9:0] fa; logic [15:0] fd;
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0400, 16'h0000, 1, 16'h9999, r, s, ok, fwe, fa, fd);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL range_retire got=%b exp=1", ok); end
    total++; if (r != 0 || s != 0) begin bad++; $display("FAIL range_cycles got=req%0d/stall%0d exp=0/0", r, s); end
    total++; if (err_range !== 1'b1) begin bad++; $display("FAIL range_err got=%b exp=1", err_range); end
    total++; if ({wme_out, ni_out} !== 2'b01) begin bad++; $display("FAIL range_bubble got=%b exp=01", {wme_out, ni_out}); end
    total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL range_no_timeout got=%b exp=0", err_timeout); end
    set_bubble();
    $display("out of range: err_range=%b", err_range);
  endtask

  task automatic test_timeout();
    int r, s; logic ok, fwe; logic [9:0] fa; logic [15:0] fd;
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 0, 16'h0000, r, s, ok, fwe, fa, fd);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL timeout_retire got=%b exp=1", ok); end
    total++; if (r != 16) begin bad++; $display("FAIL timeout_req_cycles got=%0d exp=16", r); end
    total++; if (s != 16) begin bad++; $display("FAIL timeout_stall_cycles got=%0d exp=16", s); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", err_timeout); end
    total++; if ({wme_out, ni_out} !== 2'b01) begin bad++; $display("FAIL timeout_bubble got=%b exp=01", {wme_out, ni_out}); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL timeout_req_drop got=%b exp=0", mem_req); end
    total++; if (read_data_out !== 16'h00AB) begin bad++; $display("FAIL timeout_rdata_held got=%h exp=00ab", read_data_out); end
    set_bubble();
    $display("timeout: req=%0d stall=%0d", r, s);
  endtask

  task automatic test_back_to_back();
    int r, s; logic ok, fwe; logic [9:0] fa; logic [15:0] fd;
    run_mem_op(1'b1, 1'b0, 1'b1, 1'b0, 16'h0007, 16'h0000, 2, 16'h0077, r, s, ok, fwe, fa, fd);
    total++; if (ok !== 1'b1 || r != 2 || s != 2) begin bad++; $display("FAIL b2b_first got=ok%b/req%0d/stall%0d exp=1/2/2", ok, r, s); end
    total++; if (read_data_out !== 16'h0077) begin bad++; $display("FAIL b2b_rdata got=%h exp=0077", read_data_out); end
    run_mem_op(1'b1, 1'b1, 1'b0, 1'b0, 16'h03FF, 16'hBEEF, 1, 16'h1111, r, s, ok, fwe, fa, fd);
    total++; if (ok !== 1'b1 || r != 1 || s != 1) begin bad++; $display("FAIL b2b_second got=ok%b/req%0d/stall%0d exp=1/1/1", ok, r, s); end
    total++; if ({fwe, fa, fd} !== {1'b1, 10'h3FF, 16'hBEEF}) begin bad++; $display("FAIL b2b_store_prio got=%b/%h/%h exp=1/3ff/beef", fwe, fa, fd); end
    total++; if (read_data_out !== 16'h0077) begin bad++; $display("FAIL b2b_rdata_held got=%h exp=0077", read_data_out); end
    set_bubble();
    $display("back to back: second addr=%h data=%h", fa, fd);
  endtask

  task automatic test_spurious_ack();
    set_bubble();
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    #1;
    total++; if ({stall, mem_req} !== 2'b00) begin bad++; $display("FAIL spur_stall_req got=%b exp=00", {stall, mem_req}); end
    tick(); tick();
    total++; if (read_data_out !== 16'h0077) begin bad++; $display("FAIL spur_rdata got=%h exp=0077", read_data_out); end
    total++; if ({mem_req, ni_out} !== 2'b01) begin bad++; $display("FAIL spur_state got=%b exp=01", {mem_req, ni_out}); end
    mem_ack = 1'b0;
    $display("spurious ack: ignored, rdata=%h", read_data_out);
  endtask

  task automatic test_reset_mid_access();
    ni_in = 1'b0; mm_in = 1'b1; wm_in = 1'b0; wme_in = 1'b1; wbs_in = 1'b1;
    ALUresult_in = 16'h0021; memData_in = 16'h0000; mem_ack = 1'b0;
    tick(); tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_req_before got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_bubble();
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_req_after got=%b exp=0", mem_req); end
    total++; if ({mem_we, mem_addr, mem_wdata} !== 27'h0) begin bad++; $display("FAIL mid_req_fields got=%b/%h/%h exp=0/000/0000", mem_we, mem_addr, mem_wdata); end
    total++; if ({wbs_out, wme_out, ni_out} !== 3'b001) begin bad++; $display("FAIL mid_ctrl got=%b exp=001", {wbs_out, wme_out, ni_out}); end
    total++; if ({alu_result_out, read_data_out} !== 32'h0) begin bad++; $display("FAIL mid_data got=%h/%h exp=0000/0000", alu_result_out, read_data_out); end
    total++; if ({err_timeout, err_range} !== 2'b00) begin bad++; $display("FAIL mid_err got=%b exp=00", {err_timeout, err_range}); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL mid_stall got=%b exp=0", stall); end
    $display("reset mid access: request abandoned");
  endtask

  initial begin
    rst_n = 1'b0;
    set_bubble();
    test_reset();
    test_alu_passthrough();
    test_load();
    test_store();
    test_out_of_range();
    test_timeout();
    test_back_to_back();
    test_spurious_ack();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
